// File: rtl/button_shift_scanner.sv
// Button shift-chain scanner.
//
// Periodically drives a parallel-in/serial-out shift register (active-low
// parallel load, rising-edge shift clock), collects N_BITS button levels,
// debounces every bit on its own and presents a pressed-high button vector
// together with one-cycle press pulses.
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-high
//   enable      1 = periodic scans may start
//   shift_out   serial data from the chain, 0 = button pressed
//   shift_load  active-low parallel load to the chain (registered)
//   shift_clkin shift clock to the chain (registered)
//   buttons     debounced button state, 1 = pressed
//   pressed     one-cycle pulse per bit on a 0->1 change of buttons
//   scan_done   one-cycle pulse when a scan's result is applied
module button_shift_scanner #(
  parameter int unsigned N_BITS         = 16,
  parameter int unsigned CLK_DIV        = 16,
  parameter int unsigned SCAN_INTERVAL  = 50000,
  parameter int unsigned DEBOUNCE_COUNT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              shift_out,
  output logic              shift_load,
  output logic              shift_clkin,
  output logic [N_BITS-1:0] buttons,
  output logic [N_BITS-1:0] pressed,
  output logic              scan_done
);

  localparam int unsigned IntW = $clog2(SCAN_INTERVAL);
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(N_BITS);
  localparam int unsigned CntW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLow,
    StHigh,
    StUpdate
  } state_e;

  state_e state_q, state_d;

  logic [IntW-1:0]   icnt_q, icnt_d;
  logic              tick;
  logic [DivW-1:0]   div_q, div_d;
  logic              div_last;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [BitW-1:0]   sample_idx;
  logic [N_BITS-1:0] shreg_q, shreg_d;
  logic [N_BITS-1:0] raw;
  logic [CntW-1:0]   cnt_q [N_BITS];
  logic [CntW-1:0]   cnt_d [N_BITS];
  logic [N_BITS-1:0] buttons_q, buttons_d;
  logic [N_BITS-1:0] pressed_q, pressed_d;
  logic              scan_done_q, scan_done_d;
  logic              shift_load_q, shift_load_d;
  logic              shift_clkin_q, shift_clkin_d;

  // ---------------------------------------------------------------------------
  // Free-running scan interval counter
  // ---------------------------------------------------------------------------
  assign tick = (icnt_q == IntW'(SCAN_INTERVAL - 1));

  always_comb begin
    icnt_d = tick ? '0 : icnt_q + IntW'(1);
  end

  // ---------------------------------------------------------------------------
  // Per-state cycle divider: LOAD, LOW and HIGH each last CLK_DIV cycles and
  // always leave on div_last, so the divider naturally restarts at zero.
  // ---------------------------------------------------------------------------
  assign div_last = (div_q == DivW'(CLK_DIV - 1));

  always_comb begin
    div_d = '0;
    if (state_q == StLoad || state_q == StLow || state_q == StHigh) begin
      div_d = div_last ? '0 : div_q + DivW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Ticks seen outside IDLE are simply ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    case (state_q)
      StIdle: begin
        if (tick && enable) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (div_last) begin
          state_d = StLow;
          bit_d   = '0;
        end
      end
      StLow: begin
        if (div_last) begin
          state_d = (bit_q == BitW'(N_BITS - 1)) ? StUpdate : StHigh;
        end
      end
      StHigh: begin
        if (div_last) begin
          state_d = StLow;
          bit_d   = bit_q + BitW'(1);
        end
      end
      StUpdate: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Decoded from the next state and registered, so the pins
  // change exactly on the clock edge that enters a state and never glitch.
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_load_d  = (state_d != StLoad);
    shift_clkin_d = (state_d == StHigh);
  end

  // ---------------------------------------------------------------------------
  // Serial capture: the first bit out of the chain lands in the MSB.
  // Sampling on the last LOW cycle gives the chain a full half period of
  // settling after the previous shift edge.
  // ---------------------------------------------------------------------------
  assign sample_idx = BitW'(N_BITS - 1) - bit_q;

  always_comb begin
    shreg_d = shreg_q;
    if (state_q == StLow && div_last) begin
      shreg_d[sample_idx] = shift_out;
    end
  end

  // Chain levels are active-low.
  assign raw = ~shreg_q;

  // ---------------------------------------------------------------------------
  // Debounce: a bit flips only after DEBOUNCE_COUNT consecutive scans that
  // disagree with it; any agreeing scan clears its counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    buttons_d = buttons_q;
    for (int i = 0; i < int'(N_BITS); i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (state_q == StUpdate) begin
      for (int i = 0; i < int'(N_BITS); i++) begin
        if (raw[i] == buttons_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] + CntW'(1) == CntW'(DEBOUNCE_COUNT)) begin
          buttons_d[i] = ~buttons_q[i];
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    scan_done_d = (state_q == StUpdate);
    pressed_d   = '0;
    if (state_q == StUpdate) begin
      // Rising edges only; releases produce no pulse.
      pressed_d = buttons_d & ~buttons_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      icnt_q        <= '0;
      div_q         <= '0;
      bit_q         <= '0;
      shreg_q       <= '1;
      buttons_q     <= '0;
      pressed_q     <= '0;
      scan_done_q   <= 1'b0;
      shift_load_q  <= 1'b1;
      shift_clkin_q <= 1'b0;
      for (int i = 0; i < int'(N_BITS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      icnt_q        <= icnt_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      shreg_q       <= shreg_d;
      buttons_q     <= buttons_d;
      pressed_q     <= pressed_d;
      scan_done_q   <= scan_done_d;
      shift_load_q  <= shift_load_d;
      shift_clkin_q <= shift_clkin_d;
      for (int i = 0; i < int'(N_BITS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign shift_load  = shift_load_q;
  assign shift_clkin = shift_clkin_q;
  assign buttons     = buttons_q;
  assign pressed     = pressed_q;
  assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_button_shift_scanner.sv
// Bench for button_shift_scanner: a board-level shift-chain model, a scan
// schedule / debounce reference checked every cycle, and directed scenarios.
module tb_button_shift_scanner;

  localparam int NB       = 16;
  localparam int CD       = 2;
  localparam int SI       = 100;
  localparam int DC       = 3;
  localparam int SCAN_LEN = 2 * NB * CD + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          shift_out = 1'b1;
  logic          shift_load;
  logic          shift_clkin;
  logic [NB-1:0] buttons;
  logic [NB-1:0] pressed;
  logic          scan_done;

  logic [NB-1:0] press = '0;  // physical buttons held, 1 = held
  int            n_vec = 0;
  int            n_err = 0;
  bit            chk_on = 1'b0;

  button_shift_scanner #(
    .N_BITS        (NB),
    .CLK_DIV       (CD),
    .SCAN_INTERVAL (SI),
    .DEBOUNCE_COUNT(DC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .shift_out  (shift_out),
    .shift_load (shift_load),
    .shift_clkin(shift_clkin),
    .buttons    (buttons),
    .pressed    (pressed),
    .scan_done  (scan_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Board shift chain: parallel load while shift_load is low, shift toward
  // the output on each rising shift_clkin. Bit i of the chain holds button i.
  logic [NB-1:0] sr = '1;
  logic          clk_prev = 1'b0;
  always @(negedge clock) begin
    if (shift_load === 1'b0) begin
      sr = ~press;
    end else if (shift_clkin === 1'b1 && !clk_prev) begin
      sr = {sr[NB-2:0], 1'b1};
    end
    clk_prev  = (shift_clkin === 1'b1);
    shift_out = sr[NB-1];
  end

  // Reference: scan schedule from the interval arithmetic, debounce from the
  // counting rule applied to the buttons held when the scan was launched.
  int            m_icnt = 0;
  int            m_sp = 0;  // 1-based cycle within the current scan, 0 = idle
  int            m_cnt[NB];
  logic [NB-1:0] m_raw = '0;
  logic [NB-1:0] m_btn = '0;
  logic [NB-1:0] m_pressed = '0;
  logic          m_done = 1'b0;
  logic          m_load = 1'b1;
  logic          m_clk = 1'b0;

  always @(posedge clock) begin
    logic          tick;
    logic [NB-1:0] old;
    if (reset) begin
      m_icnt = 0;
      m_sp = 0;
      m_btn = '0;
      m_pressed = '0;
      m_done = 1'b0;
      for (int i = 0; i < NB; i++) m_cnt[i] = 0;
    end else begin
      tick = (m_icnt == SI - 1);
      m_icnt = tick ? 0 : m_icnt + 1;
      m_pressed = '0;
      m_done = 1'b0;
      if (m_sp == SCAN_LEN) begin
        old = m_btn;
        for (int i = 0; i < NB; i++) begin
          if (m_raw[i] == m_btn[i]) m_cnt[i] = 0;
          else if (m_cnt[i] + 1 == DC) begin
            m_btn[i] = ~m_btn[i];
            m_cnt[i] = 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end
        m_pressed = m_btn & ~old;
        m_done = 1'b1;
        m_sp = 0;
      end else if (m_sp > 0) begin
        m_sp = m_sp + 1;
      end else if (tick && enable) begin
        m_sp = 1;
        m_raw = press;
      end
    end
    m_load = !(m_sp >= 1 && m_sp <= CD);
    m_clk = (m_sp > CD) && (m_sp < SCAN_LEN) && ((((m_sp - CD - 1) / CD) % 2) == 1);
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("model shift_load", 32'(shift_load), 32'(m_load));
      chk("model shift_clkin", 32'(shift_clkin), 32'(m_clk));
      chk("model buttons", 32'(buttons), 32'(m_btn));
      chk("model pressed", 32'(pressed), 32'(m_pressed));
      chk("model scan_done", 32'(scan_done), 32'(m_done));
    end
  end

  // Called at a negedge; returns the number of negedges until shift_load is low.
  task automatic wait_load(output int n);
    n = 0;
    while (shift_load !== 1'b0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (scan_done !== 1'b1 && n < 300);
    chk("scan_done within bound", 32'(scan_done), 32'd1);
  endtask

  // Leaves the bench at the negedge of the first cycle after reset.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int            n;
    int            lo, rises, run, minh, maxh, done_t, dones;
    logic          prev;
    bit            pat[6];
    pat = '{1, 1, 0, 1, 1, 0};

    @(negedge clock);
    chk_on = 1'b1;
    chk("reset shift_load", 32'(shift_load), 32'd1);
    chk("reset shift_clkin", 32'(shift_clkin), 32'd0);
    chk("reset buttons", 32'(buttons), 32'd0);
    do_reset();

    // 1: first scan timing
    wait_load(n);
    chk("first load latency", 32'(n), 32'd100);
    lo = 0; rises = 0; run = 0; minh = 99; maxh = 0; done_t = -1; dones = 0; prev = 1'b0;
    for (int t = 0; t < 70; t++) begin
      if (shift_load === 1'b0) lo++;
      if (shift_clkin === 1'b1) begin
        if (!prev) rises++;
        run++;
      end else if (prev) begin
        if (run < minh) minh = run;
        if (run > maxh) maxh = run;
        run = 0;
      end
      prev = (shift_clkin === 1'b1);
      if (scan_done === 1'b1) begin
        dones++;
        done_t = t;
      end
      @(negedge clock);
    end
    chk("load low cycles", 32'(lo), 32'd2);
    chk("shift clock pulses", 32'(rises), 32'd15);
    chk("min high width", 32'(minh), 32'd2);
    chk("max high width", 32'(maxh), 32'd2);
    chk("scan_done offset", 32'(done_t), 32'd65);
    chk("scan_done count", 32'(dones), 32'd1);

    // 2: bit 5 held
    press = 16'h0020;
    wait_done();
    chk("bit5 scan1 buttons", 32'(buttons), 32'h0);
    wait_done();
    chk("bit5 scan2 buttons", 32'(buttons), 32'h0);
    wait_done();
    chk("bit5 scan3 buttons", 32'(buttons), 32'h0020);
    chk("bit5 scan3 pressed", 32'(pressed), 32'h0020);
    @(negedge clock);
    chk("bit5 pressed cleared", 32'(pressed), 32'h0);
    chk("scan_done cleared", 32'(scan_done), 32'd0);
    press = '0;
    repeat (3) wait_done();
    chk("bit5 released", 32'(buttons), 32'h0);

    // 3: bounce never reaches the threshold
    for (int k = 0; k < 6; k++) begin
      press = pat[k] ? 16'h0020 : 16'h0000;
      wait_done();
      chk("bounce buttons", 32'(buttons), 32'h0);
      chk("bounce pressed", 32'(pressed), 32'h0);
    end

    // 4: bit ordering with both ends of the chain
    press = 16'h8001;
    wait_done();
    wait_done();
    chk("ends scan2 buttons", 32'(buttons), 32'h0);
    wait_done();
    chk("ends buttons", 32'(buttons), 32'h8001);
    chk("ends pressed", 32'(pressed), 32'h8001);
    press = '0;
    for (int k = 0; k < 3; k++) begin
      wait_done();
      chk("release pressed", 32'(pressed), 32'h0);
    end
    chk("ends released", 32'(buttons), 32'h0);

    // 5: reset during HIGH of bit 7
    press = 16'h0008;
    repeat (3) wait_done();
    chk("bit3 buttons", 32'(buttons), 32'h0008);
    wait_load(n);
    chk("load before reset", 32'(shift_load), 32'd0);
    repeat (32) @(negedge clock);
    chk("in bit7 high", 32'(shift_clkin), 32'd1);
    reset = 1'b1;
    press = '0;
    @(negedge clock);
    chk("mid reset shift_load", 32'(shift_load), 32'd1);
    chk("mid reset shift_clkin", 32'(shift_clkin), 32'd0);
    chk("mid reset buttons", 32'(buttons), 32'h0);
    reset = 1'b0;
    wait_load(n);
    chk("load after mid reset", 32'(n), 32'd100);

    // 6: enable gating
    @(negedge clock);
    enable = 1'b0;
    do_reset();
    lo = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clock);
      if (shift_load === 1'b0) lo++;
    end
    chk("no load while disabled", 32'(lo), 32'd0);
    repeat (50) @(negedge clock);
    enable = 1'b1;
    wait_load(n);
    chk("load on next tick", 32'(n), 32'd50);
    wait_done();
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
